// File: rtl/seven_seg_if.sv
// Display bus between the status logic (master) and the scan driver (slave).
interface seven_seg_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      load;
   logic [4*NUM_DIGITS-1:0]   bcd_in;
   logic [NUM_DIGITS-1:0]     dp_in;
   logic                      blank_lz;
   logic [NUM_DIGITS-1:0]     blink_en;
   logic [6:0]                seg;
   logic                      dp;
   logic [NUM_DIGITS-1:0]     an;
   logic                      frame_done;

   modport master (
      output load, bcd_in, dp_in, blank_lz, blink_en,
      input  seg, dp, an, frame_done
   );

   modport slave (
      input  load, bcd_in, dp_in, blank_lz, blink_en,
      output seg, dp, an, frame_done
   );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed BCD 7-segment driver with double-buffered digits,
// leading-zero blanking, per-digit blink, anode dead time and output polarity.
module seven_seg_scan #(
   parameter int NUM_DIGITS     = 4,
   parameter int SCAN_DIV       = 1000,
   parameter int BLINK_FRAMES   = 64,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input logic        clk,
   input logic        rst,
   seven_seg_if.slave bus
);
   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES - 1);

   logic [PW-1:0]                 p;
   logic [IW-1:0]                 idx;
   logic [BW-1:0]                 bcnt;
   logic                          phase;
   logic [NUM_DIGITS-1:0][3:0]    shadow, disp;
   logic [NUM_DIGITS-1:0]         sdp, ddp;
   logic                          wrap;

   logic [NUM_DIGITS:0]           zrun;
   logic [NUM_DIGITS-1:0]         lz;
   logic [6:0]                    seg_n;
   logic                          dp_n;
   logic [NUM_DIGITS-1:0]         an_n;

   // Segment pattern in lit=1 form, {g,f,e,d,c,b,a}; codes 10..15 show nothing.
   function automatic logic [6:0] dec(input logic [3:0] v);
      case (v)
         4'd0:    dec = 7'h3F;
         4'd1:    dec = 7'h06;
         4'd2:    dec = 7'h5B;
         4'd3:    dec = 7'h4F;
         4'd4:    dec = 7'h66;
         4'd5:    dec = 7'h6D;
         4'd6:    dec = 7'h7D;
         4'd7:    dec = 7'h07;
         4'd8:    dec = 7'h7F;
         4'd9:    dec = 7'h6F;
         default: dec = 7'h00;
      endcase
   endfunction

   assign wrap = (idx == I_LAST) && (p == P_LAST);

   // zrun[g] is set when digit g and every digit above it hold zero.
   assign zrun[NUM_DIGITS] = 1'b1;
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lz
      assign zrun[g] = zrun[g+1] & (disp[g] == 4'd0);
      if (g == 0) begin : g_lsd
         assign lz[g] = 1'b0;
      end else begin : g_hi
         assign lz[g] = zrun[g];
      end
   end

   // Prescaler, digit index and blink phase; everything wraps on its terminal value.
   always_ff @(posedge clk) begin
      if (rst) begin
         p     <= '0;
         idx   <= '0;
         bcnt  <= '0;
         phase <= 1'b0;
      end else begin
         if (p == P_LAST) begin
            p   <= '0;
            idx <= (idx == I_LAST) ? '0 : idx + IW'(1);
         end else begin
            p <= p + PW'(1);
         end
         if (wrap) begin
            if (bcnt == B_LAST) begin
               bcnt  <= '0;
               phase <= ~phase;
            end else begin
               bcnt <= bcnt + BW'(1);
            end
         end
      end
   end

   // Shadow captures loads; display only changes on the frame wrap so a frame never tears.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow <= '1;
         disp   <= '1;
         sdp    <= '0;
         ddp    <= '0;
      end else begin
         if (bus.load) begin
            shadow <= bus.bcd_in;
            sdp    <= bus.dp_in;
         end
         if (wrap) begin
            disp <= bus.load ? bus.bcd_in : shadow;
            ddp  <= bus.load ? bus.dp_in  : sdp;
         end
      end
   end

   // Next output pattern (lit=1) from the current slot; slot start (p==0) is anode dead time.
   always_comb begin
      an_n  = '0;
      seg_n = '0;
      dp_n  = 1'b0;
      if (p != '0) begin
         an_n[idx] = 1'b1;
         seg_n     = dec(disp[idx]);
         dp_n      = ddp[idx];
         if (bus.blank_lz && lz[idx])
            seg_n = '0;
         if (phase && bus.blink_en[idx]) begin
            seg_n = '0;
            dp_n  = 1'b0;
         end
      end
   end

   // Registered pins with polarity applied; frame_done marks the wrap edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.seg        <= {7{SEG_ACTIVE_LOW}};
         bus.dp         <= SEG_ACTIVE_LOW;
         bus.an         <= {NUM_DIGITS{AN_ACTIVE_LOW}};
         bus.frame_done <= 1'b0;
      end else begin
         bus.seg        <= seg_n ^ {7{SEG_ACTIVE_LOW}};
         bus.dp         <= dp_n ^ SEG_ACTIVE_LOW;
         bus.an         <= an_n ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
         bus.frame_done <= wrap;
      end
   end
endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: 4 digits, 4 clocks/slot, 2-frame blink, active-low pins.
module tb_seven_seg_scan;
   localparam int ND = 4;
   localparam int SD = 4;
   localparam int BF = 2;
   localparam int FL = ND * SD;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seven_seg_if #(.NUM_DIGITS(ND)) bus ();

   seven_seg_scan #(
      .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF),
      .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_chk  = 0;
   int n_fail = 0;
   logic [12:0] exp_q[$];   // {an, dp, seg, frame_done}

   // Reference state: position within the frame and frames since reset.
   int          pos, frame, cyc, last_fd;
   logic [15:0] m_sh, m_disp;
   logic [3:0]  m_sdp, m_ddp;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Active-low segment codes, written straight from the display table.
   function automatic logic [6:0] seg_lo(input logic [3:0] v);
      case (v)
         4'd0:    seg_lo = 7'b1000000;
         4'd1:    seg_lo = 7'b1111001;
         4'd2:    seg_lo = 7'b0100100;
         4'd3:    seg_lo = 7'b0110000;
         4'd4:    seg_lo = 7'b0011001;
         4'd5:    seg_lo = 7'b0010010;
         4'd6:    seg_lo = 7'b0000010;
         4'd7:    seg_lo = 7'b1111000;
         4'd8:    seg_lo = 7'b0000000;
         4'd9:    seg_lo = 7'b0010000;
         default: seg_lo = 7'b1111111;
      endcase
   endfunction

   // Predict the pins after the coming edge, push, clock, then pop and compare.
   task automatic tick();
      logic [12:0] e, got;
      logic [3:0]  anv;
      logic [6:0]  segv;
      logic        dpv, blz;
      int          d, ps;
      string       tag;
      d = 0; ps = 0;
      if (rst) begin
         e      = {4'hF, 1'b1, 7'h7F, 1'b0};
         pos    = 0;
         frame  = 0;
         m_sh   = 16'hFFFF;
         m_disp = 16'hFFFF;
         m_sdp  = 4'h0;
         m_ddp  = 4'h0;
         last_fd = -1;
      end else begin
         d    = pos / SD;
         ps   = pos % SD;
         anv  = 4'hF;
         segv = 7'h7F;
         dpv  = 1'b1;
         if (ps != 0) begin
            anv = ~(4'b0001 << d);
            blz = 1'b0;
            if (bus.blank_lz && d > 0) begin
               blz = 1'b1;
               for (int j = d; j < ND; j++)
                  if (m_disp[j*4 +: 4] != 4'd0) blz = 1'b0;
            end
            segv = blz ? 7'h7F : seg_lo(m_disp[d*4 +: 4]);
            dpv  = ~m_ddp[d];
            if (((frame / BF) % 2 == 1) && bus.blink_en[d]) begin
               segv = 7'h7F;
               dpv  = 1'b1;
            end
         end
         e = {anv, dpv, segv, (pos == FL - 1)};
         if (pos == FL - 1) begin
            m_disp = bus.load ? bus.bcd_in : m_sh;
            m_ddp  = bus.load ? bus.dp_in  : m_sdp;
            frame++;
         end
         if (bus.load) begin
            m_sh  = bus.bcd_in;
            m_sdp = bus.dp_in;
         end
         pos = (pos + 1) % FL;
      end
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      cyc++;
      got = {bus.an, bus.dp, bus.seg, bus.frame_done};
      tag = rst ? "reset" : $sformatf("out d%0d p%0d f%0d", d, ps, frame);
      chk(tag, {19'd0, got}, {19'd0, exp_q.pop_front()});
      if (!rst && bus.frame_done) begin
         if (last_fd >= 0) chk("fd_period", cyc - last_fd, FL);
         last_fd = cyc;
      end
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic ld(input logic [15:0] v, input logic [3:0] dpi);
      bus.load   = 1'b1;
      bus.bcd_in = v;
      bus.dp_in  = dpi;
      tick();
      bus.load   = 1'b0;
   endtask

   task automatic goto_pos(input int target);
      for (int k = 0; k < FL && pos != target; k++) tick();
   endtask

   initial begin
      cyc = 0; last_fd = -1;
      rst = 1'b1;
      bus.load = 1'b0; bus.bcd_in = '0; bus.dp_in = '0;
      bus.blank_lz = 1'b0; bus.blink_en = '0;
      run(3);
      rst = 1'b0;
      run(2);

      // plain digits
      ld(16'h1234, 4'h0);
      run(40);

      // leading-zero blanking
      bus.blank_lz = 1'b1;
      ld(16'h0070, 4'h0);
      run(32);
      ld(16'h0000, 4'h0);
      run(32);

      // blank codes and decimal point, including dp on LZ-blanked digits
      ld(16'hA5F9, 4'b0100);
      run(32);
      ld(16'h0005, 4'b1010);
      run(32);

      // blink on digit 0 across several blink periods
      bus.blank_lz = 1'b0;
      bus.blink_en = 4'b0001;
      ld(16'h1234, 4'b0001);
      run(FL * 8);
      bus.blink_en = 4'b0000;

      // mid-frame load waits for wrap; load on the wrap edge bypasses shadow
      goto_pos(5);
      ld(16'h5678, 4'h0);
      run(20);
      goto_pos(FL - 1);
      ld(16'h9087, 4'b1000);
      run(20);

      // reset in mid-frame
      goto_pos(9);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      run(40);

      // randomised mix
      for (int k = 0; k < 400; k++) begin
         bus.load     = ($urandom_range(0, 5) == 0);
         bus.bcd_in   = 16'($urandom);
         bus.dp_in    = 4'($urandom);
         if ($urandom_range(0, 15) == 0) bus.blank_lz = ~bus.blank_lz;
         if ($urandom_range(0, 31) == 0) bus.blink_en = 4'($urandom);
         rst          = ($urandom_range(0, 149) == 0);
         tick();
      end
      rst = 1'b0;
      bus.load = 1'b0;
      run(FL * 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
